alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 presents an operation.
REQ-005 req0_ready / req1_ready  output  1  arbiter accepts that requester's operation this cycle.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands per requester.
REQ-007 req0_ctrl / req1_ctrl  input  3  ALU control code per requester (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT).
REQ-008 alu_a, alu_b  output  WIDTH  registered operands driven to the shared ALU.
REQ-009 alu_ctrl  output  3  registered control code driven to the shared ALU.
REQ-010 alu_out  input  WIDTH, alu_zero  input  1  combinational ALU result and zero flag.
REQ-011 rsp_valid  output  1  a response is held.
REQ-012 rsp_ready  input  1  consumer takes the response.
REQ-013 rsp_out  output  WIDTH, rsp_zero  output  1, rsp_err  output  1, rsp_id  output  1  result, zero flag, illegal-code flag, originating requester.

Function
REQ-014 State machine SHALL have states IDLE, EXEC, RESP.
REQ-015 In IDLE, reqN_ready SHALL be 1 only for the granted requester, and only if its valid is 1; both readies SHALL be 0 in EXEC and RESP.
REQ-016 A transfer SHALL occur on a rising edge where reqN_valid and reqN_ready are both 1; operands, ctrl and id SHALL be latched into alu_a/alu_b/alu_ctrl/id register and state SHALL go to EXEC.
REQ-017 If only one requester is valid in IDLE, it SHALL be granted; if none, state SHALL stay IDLE.
REQ-018 In EXEC, alu_out and alu_zero SHALL be captured into rsp_out/rsp_zero, rsp_valid SHALL be 1 from the next cycle, state SHALL go to RESP.
REQ-019 Latency SHALL be exactly 2 cycles from transfer edge to rsp_valid=1.
REQ-020 If latched ctrl is 011, 100 or 101, capture SHALL set rsp_err=1, rsp_out=0, rsp_zero=1 regardless of alu_out; else rsp_err=0.
REQ-021 In RESP, outputs SHALL hold stable until rsp_valid and rsp_ready are both 1 at a rising edge, then rsp_valid SHALL drop and state SHALL go to IDLE.
REQ-022 rsp_ready asserted outside RESP SHALL have no effect; throughput is one operation per 3 cycles minimum.
REQ-023 A last_grant register SHALL record the id of each accepted operation.

Reset
REQ-024 On reset assertion, immediately and regardless of clk: state=IDLE, rsp_valid=0, rsp_out=0, rsp_zero=0, rsp_err=0, rsp_id=0, alu_a=0, alu_b=0, alu_ctrl=000, last_grant=1.
REQ-025 Reset during EXEC or RESP SHALL discard the in-flight operation with no response produced.
REQ-026 reqN_ready SHALL be 0 while reset is asserted.

Configuration
REQ-027 With macro ALU_ARB_ROUND_ROBIN_EN defined, when both requesters are valid in IDLE the requester not equal to last_grant SHALL be granted.
REQ-028 Without ALU_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win when both are valid (fixed priority); last_grant is still updated but unused.

Verification
REQ-029 After reset, req0 a=5,b=3,ctrl=010 -> req0_ready=1 same cycle, rsp_valid 2 cycles later, rsp_out=8, rsp_zero=0, rsp_id=0, rsp_err=0.
REQ-030 req1 a=7,b=7,ctrl=110 -> rsp_out=0, rsp_zero=1, rsp_id=1; a=3,b=9,ctrl=111 -> rsp_out=1.
REQ-031 Both valid continuously, rsp_ready=1: with ALU_ARB_ROUND_ROBIN_EN grants 0,1,0,1; without it grants 0,0,0,0.
REQ-032 req0 ctrl=100 -> rsp_err=1, rsp_out=0, rsp_zero=1; next legal op -> rsp_err=0.
REQ-033 Hold rsp_ready=0 for 5 cycles in RESP with req1_valid=1 -> rsp_* stable, req1_ready=0 throughout; rsp_ready=1 -> IDLE next cycle, then req1 accepted.
REQ-034 Assert reset in EXEC -> rsp_valid=0 immediately, no response after reset release, next request behaves as REQ-029.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end for one shared combinational ALU.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin grants; default is req0 priority.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             rsp_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]       alu_ctrl_q, alu_ctrl_d;
  logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic             gnt1;
  logic             ctrl_ill;

  always_comb begin
    gnt1 = req1_valid && !req0_valid;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    if (req0_valid && req1_valid) gnt1 = !last_grant_q;
`endif
  end

  assign req0_ready = (state_q == IDLE) && !reset
                      && req0_valid && !gnt1;
  assign req1_ready = (state_q == IDLE) && !reset
                      && req1_valid && gnt1;

  // Codes 011/100/101 have no ALU meaning; flag them.
  assign ctrl_ill = (alu_ctrl_q == 3'b011)
                 || (alu_ctrl_q == 3'b100)
                 || (alu_ctrl_q == 3'b101);

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_out_d    = rsp_out_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    rsp_valid_d  = rsp_valid_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (req0_ready || req1_ready) begin
          alu_a_d      = req1_ready ? req1_a : req0_a;
          alu_b_d      = req1_ready ? req1_b : req0_b;
          alu_ctrl_d   = req1_ready ? req1_ctrl : req0_ctrl;
          id_d         = req1_ready;
          last_grant_d = req1_ready;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_out_d   = ctrl_ill ? '0 : alu_out;
        rsp_zero_d  = ctrl_ill ? 1'b1 : alu_zero;
        rsp_err_d   = ctrl_ill;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= 3'b000;
      rsp_out_q    <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_out_q    <= rsp_out_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      rsp_valid_q  <= rsp_valid_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_id    = id_q;

endmodule
